// File: rtl/spi_xip_prefetch.sv
// Single-line read prefetch buffer in front of the SPI flash APB bridge.
// XIP reads hit a line buffer; misses fetch the aligned line, other traffic is forwarded.
module spi_xip_prefetch #(
  parameter logic [31:0] flash_addr_start = 32'h1c000000,
  parameter logic [31:0] flash_addr_end   = 32'h2bffffff,
  parameter int          LINE_WORDS       = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
);
  localparam int LB     = 4 * LINE_WORDS;
  localparam int LOG2LB = $clog2(LB);
  localparam int WIDX_W = $clog2(LINE_WORDS);
  localparam int TAG_W  = 32 - LOG2LB;
  localparam logic [WIDX_W-1:0] K_LAST = WIDX_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL_SETUP, S_FILL_ACCESS, S_FWD_SETUP, S_FWD_ACCESS, S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        addr_q, addr_d, pwdata_q, pwdata_d, fwd_rdata_q, fwd_rdata_d;
  logic               pwrite_q, pwrite_d, err_q, err_d, fill_q, fill_d;
  logic               valid_q, valid_d, flush_seen_q, flush_seen_d;
  logic [3:0]         pstrb_q, pstrb_d;
  logic [2:0]         pprot_q, pprot_d;
  logic [WIDX_W-1:0]  k_q, k_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [31:0]        data_q [LINE_WORDS];
  logic               data_we;

  logic [31:0] out_paddr_q, out_paddr_d, out_pwdata_q, out_pwdata_d;
  logic        out_psel_q, out_psel_d, out_penable_q, out_penable_d;
  logic        out_pwrite_q, out_pwrite_d;
  logic [2:0]  out_pprot_q, out_pprot_d;
  logic [3:0]  out_pstrb_q, out_pstrb_d;

  logic              xip, req, hit;
  logic [WIDX_W-1:0] in_widx, lat_widx;

  assign xip      = (in_paddr >= flash_addr_start) && (in_paddr <= flash_addr_end);
  assign req      = reset && (state_q == S_IDLE) && in_psel && in_penable;
  assign hit      = req && xip && !in_pwrite && valid_q && (tag_q == in_paddr[31:LOG2LB]);
  assign in_widx  = in_paddr[LOG2LB-1:2];
  assign lat_widx = addr_q[LOG2LB-1:2];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pwrite_d     = pwrite_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    pprot_d      = pprot_q;
    k_d          = k_q;
    err_d        = err_q;
    fill_d       = fill_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    fwd_rdata_d  = fwd_rdata_q;
    flush_seen_d = (state_q == S_IDLE) ? flush : (flush_seen_q | flush);
    data_we      = 1'b0;
    in_pready    = 1'b0;
    in_prdata    = '0;
    in_pslverr   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hit) begin
          in_pready = 1'b1;
          in_prdata = data_q[in_widx];
        end else if (req && xip && in_pwrite) begin
          in_pready  = 1'b1;
          in_pslverr = 1'b1;
        end else if (req) begin
          addr_d   = in_paddr;
          pprot_d  = in_pprot;
          err_d    = 1'b0;
          fill_d   = xip;
          pwrite_d = xip ? 1'b0 : in_pwrite;
          pwdata_d = xip ? 32'h0 : in_pwdata;
          pstrb_d  = xip ? 4'h0 : in_pstrb;
          if (xip) begin
            // The old line is dead as soon as a miss starts.
            k_d     = '0;
            valid_d = 1'b0;
            tag_d   = in_paddr[31:LOG2LB];
            state_d = S_FILL_SETUP;
          end else begin
            if (in_pwrite) valid_d = 1'b0;
            state_d = S_FWD_SETUP;
          end
        end
      end
      S_FILL_SETUP: state_d = S_FILL_ACCESS;
      S_FILL_ACCESS: begin
        if (out_pready) begin
          data_we = 1'b1;
          err_d   = err_q | out_pslverr;
          if (k_q == K_LAST) begin
            state_d = S_RESP;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = S_FILL_SETUP;
          end
        end
      end
      S_FWD_SETUP: state_d = S_FWD_ACCESS;
      S_FWD_ACCESS: begin
        if (out_pready) begin
          fwd_rdata_d = out_prdata;
          err_d       = out_pslverr;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        in_pready = 1'b1;
        state_d   = S_IDLE;
        if (fill_q) begin
          in_pslverr = err_q;
          in_prdata  = err_q ? 32'h0 : data_q[lat_widx];
          valid_d    = !err_q && !flush_seen_d;
        end else begin
          in_pslverr = err_q;
          in_prdata  = fwd_rdata_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) valid_d = 1'b0;
    if (!reset) begin
      in_pready  = 1'b0;
      in_prdata  = '0;
      in_pslverr = 1'b0;
      data_we    = 1'b0;
    end

    // Downstream bus is registered: derive it from the state being entered.
    out_psel_d    = 1'b0;
    out_penable_d = 1'b0;
    out_paddr_d   = '0;
    out_pwrite_d  = 1'b0;
    out_pwdata_d  = '0;
    out_pstrb_d   = '0;
    out_pprot_d   = '0;
    case (state_d)
      S_FILL_SETUP, S_FILL_ACCESS: begin
        out_psel_d    = 1'b1;
        out_penable_d = (state_d == S_FILL_ACCESS);
        out_paddr_d   = {addr_d[31:LOG2LB], k_d, 2'b00};
        out_pprot_d   = pprot_d;
      end
      S_FWD_SETUP, S_FWD_ACCESS: begin
        out_psel_d    = 1'b1;
        out_penable_d = (state_d == S_FWD_ACCESS);
        out_paddr_d   = addr_d;
        out_pwrite_d  = pwrite_d;
        out_pwdata_d  = pwdata_d;
        out_pstrb_d   = pstrb_d;
        out_pprot_d   = pprot_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      k_q           <= '0;
      err_q         <= 1'b0;
      fill_q        <= 1'b0;
      valid_q       <= 1'b0;
      tag_q         <= '0;
      fwd_rdata_q   <= '0;
      flush_seen_q  <= 1'b0;
      out_psel_q    <= 1'b0;
      out_penable_q <= 1'b0;
      out_paddr_q   <= '0;
      out_pwrite_q  <= 1'b0;
      out_pwdata_q  <= '0;
      out_pstrb_q   <= '0;
      out_pprot_q   <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      k_q           <= k_d;
      err_q         <= err_d;
      fill_q        <= fill_d;
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      fwd_rdata_q   <= fwd_rdata_d;
      flush_seen_q  <= flush_seen_d;
      out_psel_q    <= out_psel_d;
      out_penable_q <= out_penable_d;
      out_paddr_q   <= out_paddr_d;
      out_pwrite_q  <= out_pwrite_d;
      out_pwdata_q  <= out_pwdata_d;
      out_pstrb_q   <= out_pstrb_d;
      out_pprot_q   <= out_pprot_d;
    end
  end

  always_ff @(posedge clock) begin
    if (data_we) data_q[k_q] <= out_prdata;
  end

  assign out_psel    = out_psel_q;
  assign out_penable = out_penable_q;
  assign out_paddr   = out_paddr_q;
  assign out_pwrite  = out_pwrite_q;
  assign out_pwdata  = out_pwdata_q;
  assign out_pstrb   = out_pstrb_q;
  assign out_pprot   = out_pprot_q;
endmodule
